// File: rtl/hub75_pkg.sv
// hub75_pkg: shared constants, plane write-mask helper and drain states for hub75_capture.
package hub75_pkg;
  localparam int NPLANES = 4;
  localparam logic [23:0] COL_BITS = 24'h888888;
  typedef enum logic {D_IDLE, D_SEND} drain_t;
  typedef struct packed {
    logic [23:0] mask;
    logic [23:0] data;
  } wr_t;
  // COL_BITS marks bits 23,19,15,11,7,3; plane p lands p positions below each
  function automatic wr_t plane_wr(input logic [1:0] p, input logic [5:0] rgb);
    return '{mask: COL_BITS >> p,
             data: {rgb[5], 3'b0, rgb[4], 3'b0, rgb[3], 3'b0,
                    rgb[2], 3'b0, rgb[1], 3'b0, rgb[0], 3'b0} >> p};
  endfunction
endpackage

// File: rtl/hub75_capture_if.sv
// hub75_capture_if: valid/ready pixel-pair stream with column and row tags.
interface hub75_capture_if #(
  parameter int NCOLS = 64,
  parameter int ADDR_W = 5
);
  logic pix_valid;
  logic pix_ready;
  logic [23:0] pix_data;
  logic [$clog2(NCOLS)-1:0] pix_col;
  logic [ADDR_W-1:0] pix_row;
  modport master(output pix_valid, pix_data, pix_col, pix_row, input pix_ready);
  modport slave(input pix_valid, pix_data, pix_col, pix_row, output pix_ready);
endinterface

// File: rtl/hub75_edge_sync.sv
// hub75_edge_sync: optional 2-flop synchroniser (HUB75_CAP_SYNC_EN), sample register
// and rise detect on the e bits; d bits travel the same path so they stay aligned.
module hub75_edge_sync #(
  parameter int NE = 2,
  parameter int ND = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic [NE-1:0] e,
  input  logic [ND-1:0] d,
  output logic [NE-1:0] rise,
  output logic [ND-1:0] q
);
  logic [NE+ND-1:0] s, s_q;
  logic [NE-1:0] e_d;
`ifdef HUB75_CAP_SYNC_EN
  logic [NE+ND-1:0] m1, m2;
  always_ff @(posedge clk)
    if (rst) begin
      m1 <= '0;
      m2 <= '0;
    end else begin
      m1 <= {e, d};
      m2 <= m1;
    end
  assign s = m2;
`else
  assign s = {e, d};
`endif
  always_ff @(posedge clk)
    if (rst) begin
      s_q <= '0;
      e_d <= '0;
    end else begin
      s_q <= s;
      e_d <= s_q[NE+ND-1 -: NE];
    end
  assign rise = s_q[NE+ND-1 -: NE] & ~e_d;
  assign q = s_q[ND-1:0];
endmodule

// File: rtl/hub75_capture.sv
// hub75_capture: rebuilds HUB75 bit-plane rows into a pixel-pair stream.
// Define HUB75_CAP_SYNC_EN for asynchronous panels (adds input synchronisers).
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int NCOLS = 64,
  parameter int ADDR_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic hub_clk,
  input  logic hub_lat,
  input  logic hub_oe,
  input  logic [5:0] hub_rgb,
  input  logic [ADDR_W-1:0] hub_addr,
  hub75_capture_if.master pix,
  output logic frame_err,
  output logic overrun
);
  localparam int CW = $clog2(NCOLS + 1);
  localparam int AW = $clog2(NCOLS);
  logic [1:0] rise;
  logic [5:0] rgb;
  logic [ADDR_W-1:0] addr, row, prow;
  logic oe_unused;
  hub75_edge_sync #(.NE(2), .ND(7 + ADDR_W)) u_sync (
    .clk(clk), .rst(rst), .e({hub_lat, hub_clk}), .d({hub_oe, hub_addr, hub_rgb}),
    .rise(rise), .q({oe_unused, addr, rgb})
  );
  logic [1:0][NCOLS-1:0][23:0] mem;
  logic sel, ovf, ovf_sh, bad, swap;
  logic [1:0] p;
  logic [CW-1:0] c, c_sh;
  wr_t w;
  assign w = plane_wr(p, rgb);
  assign c_sh = rise[0] && c != CW'(NCOLS) ? c + 1'b1 : c;
  assign ovf_sh = ovf | (rise[0] && c == CW'(NCOLS));
  // shift is folded in first so a coincident final clock still counts
  assign bad = c_sh != CW'(NCOLS) || ovf_sh || (p != 2'd0 && addr != row);
  assign swap = rise[1] && !bad && p == 2'(NPLANES - 1);
  always_ff @(posedge clk)
    if (rst) begin
      mem <= '0;
      sel <= 1'b0;
      ovf <= 1'b0;
      p <= '0;
      c <= '0;
      row <= '0;
      frame_err <= 1'b0;
    end else begin
      if (rise[0] && c != CW'(NCOLS))
        mem[sel][c[AW-1:0]] <= mem[sel][c[AW-1:0]] & ~w.mask | w.data;
      if (rise[1]) begin
        c <= '0;
        ovf <= 1'b0;
        p <= bad || swap ? 2'd0 : p + 2'd1;
        if (p == 2'd0 && !bad) row <= addr;
        sel <= sel ^ swap;
      end else begin
        c <= c_sh;
        ovf <= ovf_sh;
      end
      frame_err <= rise[1] && bad;
    end
  drain_t st, st_n;
  logic [AW-1:0] col, col_n;
  logic last;
  assign last = col == AW'(NCOLS - 1);
  always_ff @(posedge clk)
    if (rst) begin
      st <= D_IDLE;
      col <= '0;
      prow <= '0;
      overrun <= 1'b0;
    end else begin
      st <= st_n;
      col <= col_n;
      if (swap) prow <= row;
      overrun <= overrun | (swap && st == D_SEND);
    end
  always_comb begin
    st_n = st;
    col_n = col;
    if (swap) begin
      st_n = D_SEND;
      col_n = '0;
    end else if (pix.pix_valid && pix.pix_ready) begin
      st_n = last ? D_IDLE : D_SEND;
      col_n = last ? '0 : col + 1'b1;
    end
  end
  assign pix.pix_valid = st == D_SEND;
  assign pix.pix_data = mem[~sel][col];
  assign pix.pix_col = col;
  assign pix.pix_row = prow;
endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture: directed HUB75 row sequences against hand-built pixel pairs.
module tb_hub75_capture;
  localparam int NCOLS = 4;
  localparam int ADDR_W = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hub_clk = 1'b0, hub_lat = 1'b0, hub_oe = 1'b1;
  logic [5:0] hub_rgb = '0;
  logic [ADDR_W-1:0] hub_addr = '0;
  logic frame_err, overrun;
  int checks = 0, failures = 0;
  int err_cyc = 0, err_pulse = 0;
  logic err_prev = 1'b0;
  logic [23:0] qd[$];
  logic [1:0] qc[$];
  logic [4:0] qr[$];
  logic [3:0][23:0] pa, pb, pc;
  hub75_capture_if #(.NCOLS(NCOLS), .ADDR_W(ADDR_W)) pix ();
  hub75_capture #(.NCOLS(NCOLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe),
    .hub_rgb(hub_rgb), .hub_addr(hub_addr), .pix(pix), .frame_err(frame_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (pix.pix_valid && pix.pix_ready) begin
      qd.push_back(pix.pix_data);
      qc.push_back(pix.pix_col);
      qr.push_back(pix.pix_row);
    end
    if (frame_err) err_cyc++;
    if (frame_err && !err_prev) err_pulse++;
    err_prev = frame_err;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [5:0] pbits(input logic [23:0] v, input int p);
    return {v[23-p], v[19-p], v[15-p], v[11-p], v[7-p], v[3-p]};
  endfunction
  task automatic clr();
    err_cyc = 0;
    err_pulse = 0;
    qd.delete();
    qc.delete();
    qr.delete();
  endtask
  task automatic send_plane(input logic [4:0] a, input logic [3:0][23:0] px, input int p,
                            input int n, input bit co);
    for (int i = 0; i < n; i++) begin
      hub_rgb = i < 4 ? pbits(px[i], p) : 6'h2A;
      hub_clk = 1'b0;
      tick(3);
      hub_clk = 1'b1;
      if (co && i == n - 1) begin
        hub_addr = a;
        hub_lat = 1'b1;
      end
      tick(3);
      hub_clk = 1'b0;
      hub_lat = 1'b0;
    end
    if (!co) begin
      hub_addr = a;
      tick(3);
      hub_lat = 1'b1;
      tick(3);
      hub_lat = 1'b0;
    end
    tick(3);
  endtask
  task automatic send_row(input logic [4:0] a, input logic [3:0][23:0] px, input bit co);
    for (int p = 0; p < 4; p++) send_plane(a, px, p, 4, co);
  endtask
  task automatic expect_row(input string tag, input logic [4:0] a, input logic [3:0][23:0] px);
    for (int i = 0; i < 60 && qd.size() < 4; i++) tick(1);
    tick(4);
    check({tag, "_beats"}, qd.size(), 4);
    for (int i = 0; i < 4 && i < qd.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), qd[i], px[i]);
      check($sformatf("%s_col%0d", tag, i), qc[i], i);
      check($sformatf("%s_row%0d", tag, i), qr[i], a);
    end
    qd.delete();
    qc.delete();
    qr.delete();
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, pix.pix_valid, 0);
    check({tag, "_data"}, pix.pix_data, 0);
    check({tag, "_col"}, pix.pix_col, 0);
    check({tag, "_row"}, pix.pix_row, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_ovr"}, overrun, 0);
  endtask
  initial begin
    pa = {24'h000000, 24'hFFFFFF, 24'h123456, 24'hF0A5C3};
    pb = {24'hFEDCBA, 24'h13579B, 24'h987654, 24'h0ABCDE};
    pc = {24'hF0F0F0, 24'h0F0F0F, 24'hA5A5A5, 24'h5A5A5A};
    pix.pix_ready = 1'b1;
    tick(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    tick(2);
    clr();
    send_row(5'd5, pa, 1'b0);
    expect_row("row5", 5'd5, pa);
    check("row5_err", err_pulse, 0);
    clr();
    send_plane(5'd5, pa, 0, 3, 1'b0);
    tick(5);
    check("short_err_pulses", err_pulse, 1);
    check("short_err_width", err_cyc, 1);
    check("short_beats", qd.size(), 0);
    send_row(5'd7, pb, 1'b0);
    expect_row("after_short", 5'd7, pb);
    check("after_short_err", err_pulse, 1);
    clr();
    send_plane(5'd5, pa, 0, 5, 1'b0);
    tick(5);
    check("ovf_err_pulses", err_pulse, 1);
    check("ovf_err_width", err_cyc, 1);
    send_row(5'd2, pb, 1'b0);
    expect_row("after_ovf", 5'd2, pb);
    clr();
    send_plane(5'd5, pa, 0, 4, 1'b0);
    send_plane(5'd5, pa, 1, 4, 1'b0);
    send_plane(5'd6, pa, 2, 4, 1'b0);
    tick(20);
    check("addr_err_pulses", err_pulse, 1);
    check("addr_beats", qd.size(), 0);
    check("addr_valid", pix.pix_valid, 0);
    clr();
    @(posedge clk);
    #1 pix.pix_ready = 1'b0;
    send_row(5'd3, pa, 1'b0);
    for (int i = 0; i < 40 && !pix.pix_valid; i++) tick(1);
    tick(2);
    check("stall_valid", pix.pix_valid, 1);
    check("stall_data", pix.pix_data, pa[0]);
    check("stall_col", pix.pix_col, 0);
    check("stall_row", pix.pix_row, 3);
    check("stall_ovr", overrun, 0);
    send_row(5'd9, pb, 1'b0);
    tick(4);
    check("ovr_set", overrun, 1);
    check("ovr_data", pix.pix_data, pb[0]);
    check("ovr_col", pix.pix_col, 0);
    check("ovr_row", pix.pix_row, 9);
    check("ovr_beats", qd.size(), 0);
    @(posedge clk);
    #1 pix.pix_ready = 1'b1;
    expect_row("ovr_drain", 5'd9, pb);
    check("ovr_sticky", overrun, 1);
    clr();
    send_row(5'd11, pc, 1'b1);
    expect_row("coinc", 5'd11, pc);
    check("coinc_err", err_pulse, 0);
    check("coinc_ovr", overrun, 1);
    send_plane(5'd4, pa, 0, 4, 1'b0);
    send_plane(5'd4, pa, 1, 4, 1'b0);
    send_plane(5'd4, pa, 2, 2, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 check_idle_outputs("midrst");
    tick(1);
    rst = 1'b0;
    tick(2);
    clr();
    send_row(5'd12, pb, 1'b0);
    expect_row("post_rst", 5'd12, pb);
    check("post_rst_err", err_pulse, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
